avalon_st_frame_arbiter: RTL and testbench

//  Shares the single 16-bit Avalon-ST pixel path into the video IP between two frame sources.

---
 rtl/avalon_st_arb_pkg.sv | 19 +
 rtl/avalon_st_out_reg.sv | 61 ++++++
 rtl/avalon_st_frame_arbiter.sv | 149 ++++++++++++++
 tb/tb_avalon_st_frame_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_arb_pkg.sv
// Shared types and defaults for the two-source Avalon-ST frame arbiter.
// The optional beat-count check is enabled with `ARB_LEN_CHECK_EN.
package avalon_st_arb_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_FRAME_PIXELS = 76800;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef logic src_t;

    function automatic logic [1:0] onehot(input src_t s);
        return s ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/avalon_st_out_reg.sv
// One-stage Avalon-ST pipeline register: loads when empty or draining,
// holds while the consumer stalls.
module avalon_st_out_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_sop_i,
    input  logic              in_eop_i,
    output logic              in_ready_o,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sop_o,
    output logic              out_eop_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;

    assign in_ready_o = ~valid_q | out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
                sop_d  = in_sop_i;
                eop_d  = in_eop_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_sop_o   = sop_q;
    assign out_eop_o   = eop_q;

endmodule

// File: rtl/avalon_st_frame_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST pixel path between two sources.
// Define ARB_LEN_CHECK_EN to add the frame beat counter and len_err_out.
module avalon_st_frame_arbiter
    import avalon_st_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
`ifdef ARB_LEN_CHECK_EN
    ,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_in,
    input  logic              valid0_in,
    input  logic [DATA_W-1:0] data0_in,
    input  logic              sop0_in,
    input  logic              eop0_in,
    output logic              ready0_out,
    input  logic              valid1_in,
    input  logic [DATA_W-1:0] data1_in,
    input  logic              sop1_in,
    input  logic              eop1_in,
    output logic              ready1_out,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              sop_out,
    output logic              eop_out,
    output logic [1:0]        grant_out,
    output logic              busy_out,
    output logic              drop_err_out
`ifdef ARB_LEN_CHECK_EN
    ,
    output logic              len_err_out
`endif
);

    state_e state_q, state_d;
    src_t   sel_q, sel_d;
    src_t   last_q, last_d;

    logic              busy;
    logic              load;
    logic              req0, req1;
    logic              v_sel, sop_sel, eop_sel;
    logic [DATA_W-1:0] d_sel;
    logic              accept;

    assign busy    = (state_q == BUSY);
    assign req0    = valid0_in & sop0_in;
    assign req1    = valid1_in & sop1_in;
    assign v_sel   = sel_q ? valid1_in : valid0_in;
    assign d_sel   = sel_q ? data1_in : data0_in;
    assign sop_sel = sel_q ? sop1_in : sop0_in;
    assign eop_sel = sel_q ? eop1_in : eop0_in;
    assign accept  = busy & v_sel & load;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (enable_in && (req0 || req1)) begin
                    state_d = BUSY;
                    if (req0 && req1)
                        sel_d = ~last_q;
                    else
                        sel_d = req1 ? 1'b1 : 1'b0;
                end
            end
            BUSY: begin
                if (accept && eop_sel) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Stray non-SOP beats are swallowed only between frames.
    assign ready0_out = reset & (busy ? (~sel_q & load)
                                      : (valid0_in & ~sop0_in));
    assign ready1_out = reset & (busy ? (sel_q & load)
                                      : (valid1_in & ~sop1_in));
    assign drop_err_out = reset & ~busy &
                          ((valid0_in & ~sop0_in) | (valid1_in & ~sop1_in));

    assign busy_out  = busy;
    assign grant_out = busy ? onehot(sel_q) : 2'b00;

    avalon_st_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (reset),
        .in_valid_i (busy & v_sel),
        .in_data_i  (d_sel),
        .in_sop_i   (sop_sel),
        .in_eop_i   (eop_sel),
        .in_ready_o (load),
        .out_ready_i(ready_in),
        .out_valid_o(valid_out),
        .out_data_o (data_out),
        .out_sop_o  (sop_out),
        .out_eop_o  (eop_out)
    );

`ifdef ARB_LEN_CHECK_EN
    localparam int CW = $clog2(FRAME_PIXELS + 1);
    localparam logic [CW-1:0] FULL = CW'(FRAME_PIXELS);
    localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter idles at zero so it is clear when the next grant lands.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy)
            cnt_d = '0;
        else if (accept && cnt_q != FULL)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign len_err_out = accept & (eop_sel ? (cnt_q != LAST) : (cnt_q == LAST));
`endif

endmodule

// File: tb/tb_avalon_st_frame_arbiter.sv
// Self-checking bench for avalon_st_frame_arbiter: directed vector table,
// hand sequences for reset/length corners, and randomized frame traffic.
module tb_avalon_st_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en;
    logic        v0, s0, e0, r0;
    logic [15:0] d0;
    logic        v1, s1, e1, r1;
    logic [15:0] d1;
    logic        rin;
    logic        vo, so, eo, b, drp;
    logic [15:0] dout;
    logic [1:0]  g;
`ifdef ARB_LEN_CHECK_EN
    logic        lerr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_st_frame_arbiter #(
        .DATA_W(16)
`ifdef ARB_LEN_CHECK_EN
        ,
        .FRAME_PIXELS(4)
`endif
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .enable_in   (en),
        .valid0_in   (v0),
        .data0_in    (d0),
        .sop0_in     (s0),
        .eop0_in     (e0),
        .ready0_out  (r0),
        .valid1_in   (v1),
        .data1_in    (d1),
        .sop1_in     (s1),
        .eop1_in     (e1),
        .ready1_out  (r1),
        .ready_in    (rin),
        .valid_out   (vo),
        .data_out    (dout),
        .sop_out     (so),
        .eop_out     (eo),
        .grant_out   (g),
        .busy_out    (b),
        .drop_err_out(drp)
`ifdef ARB_LEN_CHECK_EN
        ,
        .len_err_out (lerr)
`endif
    );

    typedef struct packed {
        logic        en;
        logic        v0;
        logic [15:0] d0;
        logic        s0, e0;
        logic        v1;
        logic [15:0] d1;
        logic        s1, e1;
        logic        rin;
        logic        r0, r1, drp;
        logic        vo;
        logic [15:0] dout;
        logic        so, eo;
        logic [1:0]  g;
        logic        b;
    } vec_t;

    function automatic vec_t mk(
        input logic en_, v0_, input logic [15:0] d0_, input logic s0_, e0_,
        input logic v1_, input logic [15:0] d1_, input logic s1_, e1_,
        input logic rin_, r0_, r1_, drp_,
        input logic vo_, input logic [15:0] dout_, input logic so_, eo_,
        input logic [1:0] g_, input logic b_);
        vec_t t;
        t.en = en_; t.v0 = v0_; t.d0 = d0_; t.s0 = s0_; t.e0 = e0_;
        t.v1 = v1_; t.d1 = d1_; t.s1 = s1_; t.e1 = e1_;
        t.rin = rin_; t.r0 = r0_; t.r1 = r1_; t.drp = drp_;
        t.vo = vo_; t.dout = dout_; t.so = so_; t.eo = eo_;
        t.g = g_; t.b = b_;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; rin = 1'b1;
        v0 = 1'b0; d0 = '0; s0 = 1'b0; e0 = 1'b0;
        v1 = 1'b0; d1 = '0; s1 = 1'b0; e1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Randomized traffic: per-source beat queues and a scoreboard
    logic [17:0] src0[$], src1[$], exp0[$], exp1[$];
    int          order[$];
    int          seq = 0;

    task automatic add_frame(input int s, input int len);
        for (int i = 0; i < len; i++) begin
            logic [15:0] dd;
            logic [17:0] bt;
            dd = {s[0], seq[14:0]};
            bt = {dd, (i == 0), (i == len - 1)};
            seq++;
            if (s == 0) begin
                src0.push_back(bt); exp0.push_back(bt);
            end else begin
                src1.push_back(bt); exp1.push_back(bt);
            end
        end
    endtask

    task automatic run_traffic(input int vp, input int rp, input int maxc);
        int   p0, p1, cyc, cur, sidx;
        logic t0, t1;
        logic [17:0] got, want;
        p0 = 0; p1 = 0; cyc = 0; cur = -1;
        order.delete();
        while (!(p0 == src0.size() && p1 == src1.size() &&
                 exp0.size() == 0 && exp1.size() == 0) && cyc < maxc) begin
            en = 1'b1;
            if (!v0 && p0 < src0.size() && int'($urandom_range(99)) < vp) begin
                v0 = 1'b1; {d0, s0, e0} = src0[p0];
            end
            if (!v1 && p1 < src1.size() && int'($urandom_range(99)) < vp) begin
                v1 = 1'b1; {d1, s1, e1} = src1[p1];
            end
            rin = (int'($urandom_range(99)) < rp);
            @(negedge clk);
            t0 = v0 & r0;
            t1 = v1 & r1;
            chk("no_stray_drop", drp, 0);
            if (vo && rin) begin
                got  = {dout, so, eo};
                sidx = int'(dout[15]);
                if (so) begin
                    cur = sidx;
                    order.push_back(sidx);
                end else begin
                    chk("no_interleave", sidx, cur);
                end
                if (sidx == 0 && exp0.size() > 0) want = exp0.pop_front();
                else if (sidx == 1 && exp1.size() > 0) want = exp1.pop_front();
                else want = ~got;
                chk($sformatf("beat_src%0d", sidx), got, want);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (t0) begin p0++; v0 = 1'b0; end
            if (t1) begin p1++; v1 = 1'b0; end
        end
        chk("traffic_done_in_budget", cyc < maxc, 1);
        idle_inputs();
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    endtask

    vec_t tbl[27];
    int   exp_order[3] = '{0, 1, 0};
    int   nfr;

    initial begin
        // Source 0 4-beat frame, strays, stall, enable gating
        tbl[0]  = mk(1,1,16'h01,1,0, 0,0,0,0, 1, 0,0,0, 0,0,0,0, 2'b01,1);
        tbl[1]  = mk(1,1,16'h01,1,0, 0,0,0,0, 1, 1,0,0, 1,16'h01,1,0, 2'b01,1);
        tbl[2]  = mk(1,1,16'h02,0,0, 0,0,0,0, 1, 1,0,0, 1,16'h02,0,0, 2'b01,1);
        tbl[3]  = mk(1,1,16'h03,0,0, 0,0,0,0, 1, 1,0,0, 1,16'h03,0,0, 2'b01,1);
        tbl[4]  = mk(1,1,16'h04,0,1, 0,0,0,0, 1, 1,0,0, 1,16'h04,0,1, 2'b00,0);
        tbl[5]  = mk(1,0,0,0,0, 0,0,0,0, 1, 0,0,0, 0,0,0,0, 2'b00,0);
        tbl[6]  = mk(1,0,0,0,0, 1,16'hAA,0,0, 1, 0,1,1, 0,0,0,0, 2'b00,0);
        tbl[7]  = mk(1,0,0,0,0, 1,16'hBB,0,0, 1, 0,1,1, 0,0,0,0, 2'b00,0);
        tbl[8]  = mk(1,0,0,0,0, 0,0,0,0, 1, 0,0,0, 0,0,0,0, 2'b00,0);
        tbl[9]  = mk(1,1,16'h11,1,0, 0,0,0,0, 1, 0,0,0, 0,0,0,0, 2'b01,1);
        tbl[10] = mk(1,1,16'h11,1,0, 0,0,0,0, 1, 1,0,0, 1,16'h11,1,0, 2'b01,1);
        tbl[11] = mk(1,1,16'h12,0,0, 0,0,0,0, 0, 0,0,0, 1,16'h11,1,0, 2'b01,1);
        tbl[12] = mk(1,1,16'h12,0,0, 0,0,0,0, 0, 0,0,0, 1,16'h11,1,0, 2'b01,1);
        tbl[13] = mk(1,1,16'h12,0,0, 0,0,0,0, 0, 0,0,0, 1,16'h11,1,0, 2'b01,1);
        tbl[14] = mk(1,1,16'h12,0,0, 0,0,0,0, 1, 1,0,0, 1,16'h12,0,0, 2'b01,1);
        tbl[15] = mk(1,1,16'h13,0,0, 0,0,0,0, 1, 1,0,0, 1,16'h13,0,0, 2'b01,1);
        tbl[16] = mk(1,1,16'h14,0,1, 0,0,0,0, 1, 1,0,0, 1,16'h14,0,1, 2'b00,0);
        tbl[17] = mk(1,0,0,0,0, 0,0,0,0, 1, 0,0,0, 0,0,0,0, 2'b00,0);
        tbl[18] = mk(1,1,16'h21,1,0, 0,0,0,0, 1, 0,0,0, 0,0,0,0, 2'b01,1);
        tbl[19] = mk(0,1,16'h21,1,0, 1,16'h31,1,1, 1, 1,0,0, 1,16'h21,1,0, 2'b01,1);
        tbl[20] = mk(0,1,16'h22,0,0, 1,16'h31,1,1, 1, 1,0,0, 1,16'h22,0,0, 2'b01,1);
        tbl[21] = mk(0,1,16'h23,0,1, 1,16'h31,1,1, 1, 1,0,0, 1,16'h23,0,1, 2'b00,0);
        tbl[22] = mk(0,0,0,0,0, 1,16'h31,1,1, 1, 0,0,0, 0,0,0,0, 2'b00,0);
        tbl[23] = mk(0,0,0,0,0, 1,16'h31,1,1, 1, 0,0,0, 0,0,0,0, 2'b00,0);
        tbl[24] = mk(1,0,0,0,0, 1,16'h31,1,1, 1, 0,0,0, 0,0,0,0, 2'b10,1);
        tbl[25] = mk(1,0,0,0,0, 1,16'h31,1,1, 1, 0,1,0, 1,16'h31,1,1, 2'b00,0);
        tbl[26] = mk(1,0,0,0,0, 0,0,0,0, 1, 0,0,0, 0,0,0,0, 2'b00,0);

        idle_inputs();
        #3;
        chk("reset_outputs", {vo, dout, so, eo, g, b, drp, r0, r1}, 0);
        do_reset();
        chk("post_reset_outputs", {vo, g, b}, 0);

        for (int i = 0; i < 27; i++) begin
            en = tbl[i].en;
            v0 = tbl[i].v0; d0 = tbl[i].d0; s0 = tbl[i].s0; e0 = tbl[i].e0;
            v1 = tbl[i].v1; d1 = tbl[i].d1; s1 = tbl[i].s1; e1 = tbl[i].e1;
            rin = tbl[i].rin;
            #1;
            chk($sformatf("row%0d_ready_drop", i), {r0, r1, drp},
                {tbl[i].r0, tbl[i].r1, tbl[i].drp});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid_grant_busy", i), {vo, g, b},
                {tbl[i].vo, tbl[i].g, tbl[i].b});
            if (tbl[i].vo)
                chk($sformatf("row%0d_beat", i), {dout, so, eo},
                    {tbl[i].dout, tbl[i].so, tbl[i].eo});
        end

        // Round-robin after a tie on the first decision
        do_reset();
        add_frame(0, 2); add_frame(0, 2); add_frame(1, 2);
        run_traffic(100, 100, 200);
        chk("rr_frame_count", order.size(), 3);
        if (order.size() == 3)
            for (int i = 0; i < 3; i++)
                chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);

        // Reset mid-frame, then restart only on sop
        do_reset();
        v0 = 1'b1; d0 = 16'h41; s0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        d0 = 16'h42; s0 = 1'b0;
        #1;
        chk("midframe_beat", {vo, dout, g}, {1'b1, 16'h41, 2'b01});
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {vo, dout, so, eo, g, b, drp, r0, r1}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        chk("restart_drop_nonsop", {r0, drp, b}, {1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        d0 = 16'h51; s0 = 1'b1; e0 = 1'b1;
        @(posedge clk); #1;
        chk("restart_grant", {g, b}, {2'b01, 1'b1});
        @(posedge clk); #1;
        chk("restart_beat", {vo, dout, so, eo}, {1'b1, 16'h51, 1'b1, 1'b1});
        idle_inputs();
        @(posedge clk); #1;

`ifdef ARB_LEN_CHECK_EN
        // FRAME_PIXELS=4: frames of 3, 4 and 5 beats
        for (int L = 3; L <= 5; L++) begin
            v0 = 1'b1; d0 = 16'h60; s0 = 1'b1; e0 = (L == 1);
            @(posedge clk); #1;
            for (int i = 0; i < L; i++) begin
                d0 = 16'(16'h60 + i); s0 = (i == 0); e0 = (i == L - 1);
                #1;
                chk($sformatf("len%0d_beat%0d_err", L, i), lerr,
                    (e0 && (i + 1) != 4) || (!e0 && (i + 1) == 4));
                @(posedge clk); #1;
            end
            idle_inputs();
            @(posedge clk); #1;
        end
`endif

        // Randomized frames from both sources with gaps and back-pressure
        do_reset();
        nfr = 0;
        for (int k = 0; k < 24; k++) begin
            add_frame(k % 2 == 0 ? int'($urandom_range(1)) : (k / 2) % 2,
                      int'($urandom_range(1, 6)));
            nfr++;
        end
        run_traffic(60, 70, 4000);
        chk("random_frame_count", order.size(), nfr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule
